// File: rtl/icache_refill_controller.sv
// Instruction-cache line refill sequencer: one Avalon-MM burst per miss,
// beat assembly into a line buffer, victim way choice and a one-cycle lane write.
module icache_refill_controller #(
  parameter int unsigned number_of_sets        = 4,
  parameter int unsigned log_of_number_of_sets = 2,
  parameter int unsigned bits_for_offset       = 6,
  parameter int unsigned single_lane_size      = 8 * (2 ** bits_for_offset),
  parameter int unsigned address_width         = 32,
  parameter int unsigned mem_data_width        = 32,
  parameter int unsigned beats                 = single_lane_size / mem_data_width
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             miss_valid,
  input  logic [address_width-1:0]         miss_addr,
  input  logic [number_of_sets-1:0]        way_valid,
  output logic                             busy,
  output logic [address_width-1:0]         avm_address,
  output logic                             avm_read,
  output logic [$clog2(beats):0]           avm_burstcount,
  input  logic                             avm_waitrequest,
  input  logic [mem_data_width-1:0]        avm_readdata,
  input  logic                             avm_readdatavalid,
  output logic [single_lane_size-1:0]      line_data,
  output logic [log_of_number_of_sets-1:0] line_pos,
  output logic [address_width-1:0]         line_addr,
  output logic                             line_we,
  output logic                             refill_done
);

  localparam int unsigned CNT_W = (beats > 1) ? $clog2(beats) : 1;
  localparam int unsigned BC_W  = $clog2(beats) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_WRITE} state_t;

  state_t                           r_state;
  logic [CNT_W-1:0]                 r_cnt;
  logic [log_of_number_of_sets-1:0] r_rr;
  logic [log_of_number_of_sets-1:0] r_pos;
  logic                             r_from_rr;
  logic                             r_busy;
  logic                             r_read;
  logic                             r_we;
  logic [address_width-1:0]         r_line_addr;
  logic [single_lane_size-1:0]      r_line_data;

  logic                             w_free_found;
  logic [log_of_number_of_sets-1:0] w_free_idx;
  logic [log_of_number_of_sets-1:0] w_victim;

  // Scan from the top down so the lowest-index invalid way is the one kept.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int unsigned i = number_of_sets; i > 0; i--) begin
      if (!way_valid[i-1]) begin
        w_free_found = 1'b1;
        w_free_idx   = log_of_number_of_sets'(i - 1);
      end
    end
    w_victim = w_free_found ? w_free_idx : r_rr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr        <= '0;
      r_pos       <= '0;
      r_from_rr   <= 1'b0;
      r_busy      <= 1'b0;
      r_read      <= 1'b0;
      r_we        <= 1'b0;
      r_line_addr <= '0;
      r_line_data <= '0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (miss_valid) begin
            r_line_addr <= {miss_addr[address_width-1:bits_for_offset], {bits_for_offset{1'b0}}};
            r_pos       <= w_victim;
            r_from_rr   <= !w_free_found;
            r_busy      <= 1'b1;
            r_read      <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (!avm_waitrequest) begin
            r_read  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RECV;
            // The slave may return beat 0 in the very cycle it accepts the burst.
            if (avm_readdatavalid) begin
              r_line_data[0 +: mem_data_width] <= avm_readdata;
              r_cnt                            <= CNT_W'(1);
            end
          end
        end
        S_RECV: begin
          if (avm_readdatavalid) begin
            r_line_data[r_cnt*mem_data_width +: mem_data_width] <= avm_readdata;
            if (r_cnt == CNT_W'(beats - 1)) begin
              r_we    <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (r_from_rr) r_rr <= r_rr + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign avm_read       = r_read;
  assign avm_address    = r_line_addr;
  assign avm_burstcount = BC_W'(beats);
  assign line_data      = r_line_data;
  assign line_pos       = r_pos;
  assign line_addr      = r_line_addr;
  assign line_we        = r_we;
  assign refill_done    = r_we;

endmodule

// File: tb/tb_icache_refill_controller.sv
// Scoreboard bench for icache_refill_controller: expected lines are queued at
// miss issue and compared when the lane write strobe appears.
module tb_icache_refill_controller;

  localparam int unsigned NS = 4, LW = 2, OB = 6, LS = 512, AW = 32, DW = 32, BEATS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          miss_valid;
  logic [AW-1:0] miss_addr;
  logic [NS-1:0] way_valid;
  logic          busy;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [4:0]    avm_burstcount;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic [LS-1:0] line_data;
  logic [LW-1:0] line_pos;
  logic [AW-1:0] line_addr;
  logic          line_we;
  logic          refill_done;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] pos;
    logic [LS-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [LS-1:0] last_line;
  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  int unsigned   cyc     = 0;

  icache_refill_controller #(
    .number_of_sets(NS), .log_of_number_of_sets(LW), .bits_for_offset(OB),
    .address_width(AW), .mem_data_width(DW)
  ) dut (
    .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .way_valid(way_valid), .busy(busy), .avm_address(avm_address), .avm_read(avm_read),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .line_data(line_data), .line_pos(line_pos), .line_addr(line_addr),
    .line_we(line_we), .refill_done(refill_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full refill: miss, optional waitrequest stall, beats (optionally gapped or
  // starting in the acceptance cycle), then scoreboard compare at line_we.
  task automatic run_refill(input logic [AW-1:0] addr, input logic [NS-1:0] wv,
                            input logic [LW-1:0] pos, input int unsigned wt,
                            input bit gaps, input bit early, input logic [DW-1:0] base);
    exp_t          e;
    logic [AW-1:0] al;
    int unsigned   t0, nrd, extra_rd, k0;
    bit            seen;
    al     = {addr[AW-1:OB], {OB{1'b0}}};
    e.addr = al;
    e.pos  = pos;
    e.data = '0;
    for (int k = 0; k < BEATS; k++) e.data[k*DW +: DW] = base + DW'(k);
    sb.push_back(e);

    miss_valid = 1'b1; miss_addr = addr; way_valid = wv; avm_waitrequest = (wt != 0);
    @(posedge clk); #1;
    t0 = cyc;
    miss_valid = 1'b0;
    n_total++;
    if (busy !== 1'b1 || avm_read !== 1'b1)
      $display("FAIL accept: busy=%b avm_read=%b required 1/1", busy, avm_read);
    else n_pass++;
    n_total++;
    if (avm_address !== al || avm_burstcount !== 5'd16)
      $display("FAIL req_addr: addr=%h bc=%0d required %h/16", avm_address, avm_burstcount, al);
    else n_pass++;

    nrd = 0;
    for (int i = 0; i < int'(wt); i++) begin
      if (avm_read === 1'b1 && avm_address === al) nrd++;
      @(posedge clk); #1;
    end
    avm_waitrequest = 1'b0;
    if (avm_read === 1'b1 && avm_address === al) nrd++;
    if (early) begin avm_readdatavalid = 1'b1; avm_readdata = base; end
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    n_total++;
    if (nrd != wt + 1) $display("FAIL req_cycles: got %0d required %0d", nrd, wt + 1);
    else n_pass++;

    extra_rd = 0;
    k0 = early ? 1 : 0;
    if (!early) begin
      @(posedge clk); #1;
      if (avm_read === 1'b1) extra_rd++;
    end
    for (int k = int'(k0); k < BEATS; k++) begin
      if (gaps) repeat (k % 3) begin
        @(posedge clk); #1;
        if (avm_read === 1'b1) extra_rd++;
      end
      avm_readdatavalid = 1'b1; avm_readdata = base + DW'(k);
      @(posedge clk); #1;
      avm_readdatavalid = 1'b0;
      if (avm_read === 1'b1) extra_rd++;
    end
    n_total++;
    if (extra_rd != 0) $display("FAIL one_burst: %0d extra read cycles, required 0", extra_rd);
    else n_pass++;

    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (line_we === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    e = sb.pop_front();
    n_total++;
    if (!seen) begin
      $display("FAIL line_we_timeout: no line_we for line %h", e.addr);
    end else begin
      n_pass++;
      last_line = e.data;
      n_total++;
      if (line_data !== e.data) $display("FAIL line_data: got %h required %h", line_data, e.data);
      else n_pass++;
      n_total++;
      if (line_pos !== e.pos) $display("FAIL line_pos: got %0d required %0d", line_pos, e.pos);
      else n_pass++;
      n_total++;
      if (line_addr !== e.addr) $display("FAIL line_addr: got %h required %h", line_addr, e.addr);
      else n_pass++;
      n_total++;
      if (refill_done !== 1'b1) $display("FAIL refill_done: got %b required 1", refill_done);
      else n_pass++;
      if (wt == 0 && !gaps && !early) begin
        n_total++;
        if (cyc - t0 != BEATS + 2) $display("FAIL latency: got %0d required %0d", cyc - t0, BEATS + 2);
        else n_pass++;
      end
      @(posedge clk); #1;
      n_total++;
      if (line_we !== 1'b0 || refill_done !== 1'b0 || busy !== 1'b0)
        $display("FAIL after_write: we=%b done=%b busy=%b required 0/0/0", line_we, refill_done, busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; way_valid = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_total++;
    if (busy !== 1'b0 || avm_read !== 1'b0 || line_we !== 1'b0 || refill_done !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b read=%b we=%b done=%b required 0", busy, avm_read, line_we, refill_done);
    else n_pass++;
    n_total++;
    if (avm_address !== '0 || line_addr !== '0 || line_data !== '0 || line_pos !== '0 || avm_burstcount !== 5'd16)
      $display("FAIL reset_data: addr=%h laddr=%h pos=%0d bc=%0d required 0/0/0/16",
               avm_address, line_addr, line_pos, avm_burstcount);
    else n_pass++;
    last_line = '0;
  endtask

  task automatic test_single();
    run_refill(32'h0000_1234, 4'b0000, 2'd0, 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_waitrequest();
    run_refill(32'h0000_5678, 4'b0001, 2'd1, 5, 1'b0, 1'b0, 32'h1000);
  endtask

  task automatic test_partial_valid();
    run_refill(32'hABCD_0040, 4'b1011, 2'd2, 0, 1'b0, 1'b0, 32'h2000);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 5; i++)
      run_refill(32'h0010_0000 + 32'(i * 64), 4'b1111, LW'(i % 4), 0, 1'b0, (i == 2),
                 32'h3000 + 32'(i * 256));
  endtask

  task automatic test_gaps_stray();
    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    avm_readdatavalid = 1'b0;
    n_total++;
    if (busy !== 1'b0 || line_data !== last_line)
      $display("FAIL stray_beat: busy=%b line_data=%h required 0/%h", busy, line_data, last_line);
    else n_pass++;
    run_refill(32'h00FF_FFC8, 4'b0111, 2'd3, 2, 1'b1, 1'b0, 32'h4000);
  endtask

  task automatic test_reset_mid_burst();
    int unsigned nwe;
    miss_valid = 1'b1; miss_addr = 32'h8000_0040; way_valid = 4'b1111; avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      avm_readdatavalid = 1'b1; avm_readdata = 32'h5000 + 32'(k);
      @(posedge clk); #1;
    end
    reset = 1'b1; avm_readdata = 32'h5008;
    @(posedge clk); #1;
    reset = 1'b0;
    n_total++;
    if (busy !== 1'b0 || avm_read !== 1'b0 || line_we !== 1'b0 || line_data !== '0 ||
        line_pos !== '0 || line_addr !== '0)
      $display("FAIL mid_reset: busy=%b read=%b we=%b pos=%0d addr=%h required all 0",
               busy, avm_read, line_we, line_pos, line_addr);
    else n_pass++;
    nwe = 0;
    for (int k = 9; k < BEATS; k++) begin
      avm_readdatavalid = 1'b1; avm_readdata = 32'h5000 + 32'(k);
      @(posedge clk); #1;
      if (line_we === 1'b1) nwe++;
    end
    avm_readdatavalid = 1'b0;
    @(posedge clk); #1;
    if (line_we === 1'b1) nwe++;
    n_total++;
    if (nwe != 0 || line_data !== '0 || busy !== 1'b0)
      $display("FAIL leftover_beats: we_count=%0d busy=%b line_data=%h required 0/0/0", nwe, busy, line_data);
    else n_pass++;
    // rr was 1 before the reset; a clean reset brings the next full-set victim back to way 0
    run_refill(32'h8000_0040, 4'b1111, 2'd0, 0, 1'b0, 1'b0, 32'h6000);
  endtask

  initial begin
    test_reset();
    test_single();
    test_waitrequest();
    test_partial_valid();
    test_round_robin();
    test_gaps_stray();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
